// File: rtl/ibuf_load_sched.sv
// ibuf_load_sched: splits one input-buffer fill job into successive axibus2rambus
// loader runs. It tracks DDR address, RAM offset and run index, and pulses O_done
// when the job ends.
// Optional feature: define IBUF_SCHED_PERF_EN to add the O_perf_cycles busy-cycle counter.
module ibuf_load_sched #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
    parameter int unsigned C_RAM_ADDR_WIDTH   = 10,
    parameter int unsigned C_CNT_WIDTH        = 20
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_job_valid,
    output logic                          O_job_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_job_ddr_addr,
    input  logic [C_CNT_WIDTH-1:0]        I_job_total,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_job_burst,
    input  logic                          I_abort,
    output logic                          O_busy,
    output logic                          O_done,
    output logic                          O_ld_ap_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_ld_base_addr,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_ld_len,
    input  logic                          I_ld_ap_done,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_ram_base,
`ifdef IBUF_SCHED_PERF_EN
    output logic [31:0]                   O_perf_cycles,
`endif
    output logic [15:0]                   O_burst_idx
);

    localparam int unsigned C_BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StStart,
        StWait,
        StGap,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Second cycle of GAP when set
    logic gap_cnt_q, gap_cnt_d;

    // Job progress
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_CNT_WIDTH-1:0]        remaining_q, remaining_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   burst_q, burst_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   ram_base_q, ram_base_d;
    logic [15:0]                   burst_idx_q, burst_idx_d;

    // Registered loader-facing and handshake outputs
    logic [C_M_AXI_ADDR_WIDTH-1:0] ld_base_q, ld_base_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   ld_len_q, ld_len_d;
    logic                          ld_start_q, ld_start_d;
    logic                          done_q, done_d;
    logic                          job_ready_q, job_ready_d;

    logic                          job_accept;
    logic                          abort_act;
    logic                          run_done;
    logic [C_RAM_ADDR_WIDTH-1:0]   len_sel;

    // job_ready_q is only ever set while the FSM sits in IDLE (and is low in the reset cycle)
    assign job_accept = I_job_valid && job_ready_q && (state_q == StIdle);
    assign abort_act  = I_abort && (state_q != StIdle);
    // Abort wins over a loader done arriving in the same cycle
    assign run_done   = (state_q == StWait) && I_ld_ap_done && !I_abort;

    // ------------------------------------------------------------------
    // FSM: state register
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q   <= StIdle;
            gap_cnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (job_accept) state_d = StCalc;
                StCalc:  state_d = (remaining_q == '0) ? StDone : StStart;
                StStart: state_d = StWait;
                StWait:  if (I_ld_ap_done) state_d = StGap;
                StGap:   if (gap_cnt_q) state_d = StCalc;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        // Counts the two GAP cycles; clears whenever GAP is left or first entered
        gap_cnt_d = (state_q == StGap) && (state_d == StGap);
    end

    // FSM: output logic (next values of the registered outputs)
    always_comb begin
        // Start is a level held through START->WAIT and WAIT itself; drops on done or abort
        ld_start_d  = (state_d == StWait);
        done_d      = (state_q == StDone) && !abort_act;
        job_ready_d = (state_d == StIdle);
    end

    assign O_busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Run length: min(remaining, burst); the compare is done at counter width
    always_comb begin
        if (remaining_q < C_CNT_WIDTH'(burst_q)) begin
            len_sel = C_RAM_ADDR_WIDTH'(remaining_q);
        end else begin
            len_sel = burst_q;
        end
    end

    // Datapath next-state: job latch, per-run setup in CALC, progress update on loader done
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        ram_base_d  = ram_base_q;
        burst_idx_d = burst_idx_q;
        ld_base_d   = ld_base_q;
        ld_len_d    = ld_len_q;

        if (job_accept) begin
            addr_d      = I_job_ddr_addr;
            remaining_d = I_job_total;
            burst_d     = (I_job_burst == '0) ? C_RAM_ADDR_WIDTH'(1) : I_job_burst;
            ram_base_d  = '0;
            burst_idx_d = '0;
        end

        // Loader outputs only move here, while ap_start is low
        if ((state_q == StCalc) && !abort_act && (remaining_q != '0)) begin
            ld_len_d  = len_sel;
            ld_base_d = addr_q;
        end

        if (run_done) begin
            remaining_d = remaining_q - C_CNT_WIDTH'(ld_len_q);
            addr_d      = addr_q + C_M_AXI_ADDR_WIDTH'(ld_len_q) *
                                   C_M_AXI_ADDR_WIDTH'(C_BEAT_BYTES);
            // RAM offset wraps at the RAM address width
            ram_base_d  = ram_base_q + ld_len_q;
            burst_idx_d = burst_idx_q + 16'd1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            ram_base_q  <= '0;
            burst_idx_q <= '0;
            ld_base_q   <= '0;
            ld_len_q    <= '0;
            ld_start_q  <= 1'b0;
            done_q      <= 1'b0;
            job_ready_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            ram_base_q  <= ram_base_d;
            burst_idx_q <= burst_idx_d;
            ld_base_q   <= ld_base_d;
            ld_len_q    <= ld_len_d;
            ld_start_q  <= ld_start_d;
            done_q      <= done_d;
            job_ready_q <= job_ready_d;
        end
    end

    assign O_job_ready    = job_ready_q;
    assign O_done         = done_q;
    assign O_ld_ap_start  = ld_start_q;
    assign O_ld_base_addr = ld_base_q;
    assign O_ld_len       = ld_len_q;
    assign O_ram_base     = ram_base_q;
    assign O_burst_idx    = burst_idx_q;

`ifdef IBUF_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: clears on accept, saturates, holds while idle
    always_comb begin
        perf_d = perf_q;
        if (job_accept) begin
            perf_d = '0;
        end else if (O_busy && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Busy-cycle counter register
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign O_perf_cycles = perf_q;
`endif

endmodule
